uart_tx_arbiter: RTL and testbench

//  Shares the single Tx_uart transmitter between NUM_REQ byte producers: the interface circuit, status and debug sources.

---
 rtl/uart_tx_arbiter.sv | 163 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Round-robin arbiter that shares one UART transmitter between
//               NUM_REQ byte producers. Optional watchdog: TX_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
  parameter int NB_BITS        = 8,
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic [NUM_REQ*NB_BITS-1:0] i_data,
  output logic [NUM_REQ-1:0]         o_ack,
  output logic [NUM_REQ-1:0]         o_grant,
  output logic [NB_BITS-1:0]         o_data,
  output logic                       o_tx_start,
  input  logic                       i_tx_done,
  output logic                       o_busy,
  output logic                       o_timeout
);

  localparam int       c_IW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [1:0] c_S_IDLE  = 2'd0;
  localparam logic [1:0] c_S_START = 2'd1;
  localparam logic [1:0] c_S_WAIT  = 2'd2;

  logic [1:0]         r_state, w_state_nxt;
  logic [c_IW-1:0]    r_ptr, w_ptr_nxt;
  logic [c_IW-1:0]    r_owner, w_owner_nxt;
  logic [NUM_REQ-1:0] r_ack, w_ack_nxt;
  logic [NUM_REQ-1:0] r_grant, w_grant_nxt;
  logic [NB_BITS-1:0] r_data, w_data_nxt;
  logic               r_start, w_start_nxt;
  logic               r_busy, w_busy_nxt;
  logic               r_timeout, w_timeout_nxt;
  logic               w_found;
  logic [c_IW-1:0]    w_win;
  logic [c_IW-1:0]    w_idx;
  logic               w_expire;
  logic [NUM_REQ-1:0] w_onehot;
  logic [NB_BITS-1:0] w_bytes [NUM_REQ];

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign w_bytes[k] = i_data[k*NB_BITS +: NB_BITS];
  end

  // First active requester searching upward from r_ptr with wrap-around.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_idx = c_IW'((int'(r_ptr) + i) % NUM_REQ);
      if (!w_found && i_req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  assign w_onehot = NUM_REQ'(1) << w_win;

`ifdef TX_ARB_TIMEOUT_EN
  localparam int c_CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [c_CW-1:0] r_cnt;

  // A done pulse in the expiry cycle takes precedence over the watchdog.
  assign w_expire = (r_state == c_S_WAIT) && !i_tx_done &&
                    (r_cnt == c_CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (r_state == c_S_START) begin
      r_cnt <= '0;
    end else if (r_state == c_S_WAIT && !i_tx_done && !w_expire) begin
      r_cnt <= r_cnt + c_CW'(1);
    end
  end
`else
  // Watchdog compiled out: the comparison is constant false.
  assign w_expire = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= c_S_IDLE;
      r_ptr     <= '0;
      r_owner   <= '0;
      r_ack     <= '0;
      r_grant   <= '0;
      r_data    <= '0;
      r_start   <= 1'b0;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_owner   <= w_owner_nxt;
      r_ack     <= w_ack_nxt;
      r_grant   <= w_grant_nxt;
      r_data    <= w_data_nxt;
      r_start   <= w_start_nxt;
      r_busy    <= w_busy_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_S_IDLE:  if (w_found) w_state_nxt = c_S_START;
      c_S_START: w_state_nxt = c_S_WAIT;
      c_S_WAIT:  if (i_tx_done || w_expire) w_state_nxt = c_S_IDLE;
      default:   w_state_nxt = c_S_IDLE;
    endcase
  end

  always_comb begin
    w_ack_nxt     = '0;
    w_start_nxt   = 1'b0;
    w_timeout_nxt = 1'b0;
    w_grant_nxt   = r_grant;
    w_data_nxt    = r_data;
    w_busy_nxt    = r_busy;
    w_ptr_nxt     = r_ptr;
    w_owner_nxt   = r_owner;
    case (r_state)
      c_S_IDLE: begin
        if (w_found) begin
          w_ack_nxt   = w_onehot;
          w_grant_nxt = w_onehot;
          w_data_nxt  = w_bytes[w_win];
          w_busy_nxt  = 1'b1;
          w_owner_nxt = w_win;
        end
      end
      c_S_START: w_start_nxt = 1'b1;
      c_S_WAIT: begin
        if (i_tx_done || w_expire) begin
          w_grant_nxt   = '0;
          w_busy_nxt    = 1'b0;
          w_timeout_nxt = w_expire;
          w_ptr_nxt     = (r_owner == c_IW'(NUM_REQ - 1)) ? '0 : r_owner + c_IW'(1);
        end
      end
      default: ;
    endcase
  end

  assign o_ack      = r_ack;
  assign o_grant    = r_grant;
  assign o_data     = r_data;
  assign o_tx_start = r_start;
  assign o_busy     = r_busy;
  assign o_timeout  = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Directed bench for uart_tx_arbiter with a transaction-level
//               reference model and a Tx_uart stand-in (done 20 cycles late).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

  localparam int TO = 50;
`ifdef TX_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] data;
  logic [3:0]  ack, grant;
  logic [7:0]  odata;
  logic        start, busy, tmo;
  logic        tx_done, tx_done_m, stray;
  bit          tx_en;
  int          tx_cnt;

  int n_vec = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;
  logic [7:0] q_bytes[$];

  logic [3:0] e_ack, e_grant;
  logic [7:0] e_data;
  logic       e_start, e_busy, e_tmo;
  int         m_ptr, m_age, m_owner;

  assign tx_done = tx_done_m | stray;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NB_BITS(8), .NUM_REQ(4), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_data(data),
    .o_ack(ack), .o_grant(grant), .o_data(odata), .o_tx_start(start),
    .i_tx_done(tx_done), .o_busy(busy), .o_timeout(tmo)
  );

  // Transmitter stand-in: done pulse 20 cycles after a start is seen.
  always @(negedge clk) begin
    if (rst) begin
      tx_cnt    = 0;
      tx_done_m = 1'b0;
    end else begin
      tx_done_m = 1'b0;
      if (tx_cnt > 0) begin
        tx_cnt = tx_cnt - 1;
        if (tx_cnt == 0) tx_done_m = 1'b1;
      end
      if (tx_en && start === 1'b1) tx_cnt = 20;
    end
  end

  function automatic int pick(input logic [3:0] r, input int p);
    logic [1:0] k2;
    for (int off = 0; off < 4; off++) begin
      k2 = 2'((p + off) % 4);
      if (r[k2]) return int'(k2);
    end
    return 0;
  endfunction

  // Reference model: age = cycles since the byte was accepted.
  always @(posedge clk) begin
    if (rst) begin
      e_ack = 0; e_grant = 0; e_data = 0; e_start = 0; e_busy = 0; e_tmo = 0;
      m_ptr = 0; m_age = -1; m_owner = 0;
    end else begin
      e_ack = 0; e_start = 0; e_tmo = 0;
      if (m_age < 0) begin
        if (req != 0) begin
          m_owner = pick(req, m_ptr);
          e_ack   = 4'(1 << m_owner);
          e_grant = e_ack;
          e_data  = 8'(data >> (8 * m_owner));
          e_busy  = 1;
          m_age   = 0;
        end
      end else if (m_age == 0) begin
        e_start = 1;
        m_age   = 1;
      end else if (tx_done || (TO_EN && m_age == TO)) begin
        e_tmo   = !tx_done;
        e_grant = 0;
        e_busy  = 0;
        m_ptr   = (m_owner + 1) % 4;
        m_age   = -1;
      end else begin
        m_age = m_age + 1;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic wait_idle(input string nm);
    int k = 0;
    while (busy !== 1'b0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk({nm, " idle"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic run_frames(input logic [3:0] r, input int n, input string nm);
    int cnt = 0;
    int k = 0;
    req = r;
    while (cnt < n && k < 500) begin
      @(negedge clk);
      k++;
      if (ack != 0) cnt++;
    end
    req = 4'h0;
    chk({nm, " frames"}, cnt, n);
    wait_idle(nm);
  endtask

  initial begin
    rst = 1'b1; req = 4'hF; data = 32'h13121110; stray = 1'b0; tx_en = 1'b1;
    fork
      forever begin
        @(negedge clk);
        if (cmp_en) begin
          n_vec++;
          if ({ack, grant, odata, start, busy, tmo} !== {e_ack, e_grant, e_data, e_start, e_busy, e_tmo}) begin
            n_bad++;
            $display("FAIL cycle@%0t: ack=%b/%b grant=%b/%b data=%h/%h start=%b/%b busy=%b/%b tmo=%b/%b (actual/required)",
                     $time, ack, e_ack, grant, e_grant, odata, e_data, start, e_start, busy, e_busy, tmo, e_tmo);
          end
          if (start === 1'b1) q_bytes.push_back(odata);
        end
      end
    join_none

    // Reset held with every request active.
    repeat (3) @(negedge clk);
    cmp_en = 1'b1;
    chk("reset outputs", {ack, grant, odata, start, busy, tmo}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("first grant req0", {28'd0, ack}, 32'h1);
    req = 4'h0;
    wait_idle("reset");

    // Single requester 2 with 8'hA5.
    data = 32'h13A51110;
    req  = 4'b0100;
    @(negedge clk);
    chk("single ack", {28'd0, ack}, 32'h4);
    chk("single no early start", {31'd0, start}, 32'd0);
    req = 4'h0;
    @(negedge clk);
    chk("single start", {31'd0, start}, 32'd1);
    chk("single data", {24'd0, odata}, 32'hA5);
    wait_idle("single");
    chk("single grant cleared", {28'd0, grant}, 32'd0);

    // Wrap/skip: last grant 3, then requesters 0 and 2.
    data = 32'h13121110;
    run_frames(4'b1000, 1, "prime3");
    q_bytes.delete();
    run_frames(4'b0101, 2, "wrap");
    chk("wrap count", q_bytes.size(), 2);
    chk("wrap first", {24'd0, (q_bytes.size() > 0) ? q_bytes[0] : 8'hxx}, 32'h10);
    chk("wrap second", {24'd0, (q_bytes.size() > 1) ? q_bytes[1] : 8'hxx}, 32'h12);

    // Abort in WAIT_DONE, then a stray done in IDLE.
    req = 4'b0010;
    @(negedge clk);
    req = 4'h0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("abort grant", {28'd0, grant}, 32'd0);
    chk("abort busy", {31'd0, busy}, 32'd0);
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    repeat (2) @(negedge clk);
    chk("stray done ignored", {31'd0, busy}, 32'd0);

    // Fairness from ptr=0 after the abort.
    q_bytes.delete();
    run_frames(4'hF, 5, "fair");
    chk("fair count", q_bytes.size(), 5);
    for (int i = 0; i < 5; i++)
      chk($sformatf("fair byte%0d", i), {24'd0, (q_bytes.size() > i) ? q_bytes[i] : 8'hxx}, 32'h10 + (i % 4));

`ifdef TX_ARB_TIMEOUT_EN
    begin
      int k;
      tx_en = 1'b0;
      req   = 4'b0001;
      k = 0;
      while (ack === 4'h0 && k < 20) begin @(negedge clk); k++; end
      req = 4'b0010;
      k = 0;
      while (start !== 1'b1 && k < 20) begin @(negedge clk); k++; end
      k = 0;
      while (tmo !== 1'b1 && k < 100) begin @(negedge clk); k++; end
      chk("timeout latency", k, TO);
      tx_en = 1'b1;
      @(negedge clk);
      chk("after timeout grant", {28'd0, ack}, 32'h2);
      req = 4'h0;
      wait_idle("timeout");
    end
`endif

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
